// File: rtl/edge_frame_sequencer.sv
// Frame sequencer: UART bytes -> raster pixel stream, edge results -> FIFO -> UART tx.
// Optional macro SEQ_BORDER_ZERO_EN zeroes results that fall on the image border.
module edge_frame_sequencer #(
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     pix_valid,
  output logic [7:0]               pix_data,
  output logic [$clog2(IMG_W)-1:0] pix_col,
  output logic [$clog2(IMG_H)-1:0] pix_row,
  output logic                     pix_sof,
  output logic                     pix_eol,
  output logic                     pix_eof,
  input  logic                     res_valid,
  input  logic [7:0]               res_data,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NW = $clog2(IMG_W * IMG_H + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [NW-1:0] RES_TOTAL = NW'(IMG_W * IMG_H);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic          start_s, accept_s, rx_err_s, drain_ok_s;
  logic [CW-1:0] col_r, cur_col_s, ocol_r, cur_ocol_s;
  logic [RW-1:0] row_r, cur_row_s, orow_r, cur_orow_s;
  logic          in_eol_s, in_eof_s, o_eol_s, o_eof_s;
  logic [NW-1:0] res_cnt_r, res_base_s;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_r, rd_ptr_r;
  logic          empty_s, full_s, pop_s, push_s, drop_s;
  logic [7:0]    push_data_s;
  logic          pix_valid_r, pix_sof_r, pix_eol_r, pix_eof_r;
  logic [7:0]    pix_data_r, tx_data_r;
  logic [CW-1:0] pix_col_r;
  logic [RW-1:0] pix_row_r;
  logic          tx_start_r, busy_r, frame_done_r, err_r;

  // Input raster position; a new frame always starts at (0,0)
  always_comb begin
    cur_col_s = (state_r == IDLE) ? {CW{1'b0}} : col_r;
    cur_row_s = (state_r == IDLE) ? {RW{1'b0}} : row_r;
    in_eol_s  = (cur_col_s == COL_LAST);
    in_eof_s  = in_eol_s && (cur_row_s == ROW_LAST);
  end

  // FSM next state and per-cycle control strobes
  always_comb begin
    state_s  = state_r;
    start_s  = 1'b0;
    accept_s = 1'b0;
    rx_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx_valid) begin
          start_s  = 1'b1;
          accept_s = 1'b1;
          state_s  = in_eof_s ? DRAIN : STREAM;
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        if (rx_valid) begin
          accept_s = 1'b1;
          state_s  = in_eof_s ? DRAIN : STREAM;
        end else begin
          state_s = STREAM;
        end
      end
      DRAIN: begin
        rx_err_s = rx_valid;
        state_s  = drain_ok_s ? DONE : DRAIN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Result-side counters, FIFO status and push/pop decisions
  always_comb begin
    cur_ocol_s = start_s ? {CW{1'b0}} : ocol_r;
    cur_orow_s = start_s ? {RW{1'b0}} : orow_r;
    res_base_s = start_s ? {NW{1'b0}} : res_cnt_r;
    o_eol_s    = (cur_ocol_s == COL_LAST);
    o_eof_s    = o_eol_s && (cur_orow_s == ROW_LAST);
`ifdef SEQ_BORDER_ZERO_EN
    push_data_s = ((cur_ocol_s == {CW{1'b0}}) || o_eol_s ||
                   (cur_orow_s == {RW{1'b0}}) || (cur_orow_s == ROW_LAST)) ? 8'h00 : res_data;
`else
    push_data_s = res_data;
`endif
    empty_s    = (wr_ptr_r == rd_ptr_r);
    full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    // tx_start_r gate guarantees the two-cycle pulse spacing
    pop_s      = !empty_s && !tx_busy && !tx_start_r;
    push_s     = res_valid && (!full_s || pop_s);
    drop_s     = res_valid && full_s && !pop_s;
    drain_ok_s = (res_cnt_r == RES_TOTAL) && empty_s && !tx_busy;
  end

  // State register and frame status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      busy_r       <= (state_s == STREAM) || (state_s == DRAIN);
      frame_done_r <= (state_s == DONE);
    end
  end

  // Pixel output registers and input raster counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid_r <= 1'b0;
      pix_data_r  <= 8'h00;
      pix_col_r   <= {CW{1'b0}};
      pix_row_r   <= {RW{1'b0}};
      pix_sof_r   <= 1'b0;
      pix_eol_r   <= 1'b0;
      pix_eof_r   <= 1'b0;
      col_r       <= {CW{1'b0}};
      row_r       <= {RW{1'b0}};
    end else begin
      pix_valid_r <= accept_s;
      if (accept_s) begin
        pix_data_r <= rx_data;
        pix_col_r  <= cur_col_s;
        pix_row_r  <= cur_row_s;
        pix_sof_r  <= start_s;
        pix_eol_r  <= in_eol_s;
        pix_eof_r  <= in_eof_s;
        col_r      <= in_eol_s ? {CW{1'b0}} : cur_col_s + 1'b1;
        row_r      <= in_eol_s ? (in_eof_s ? {RW{1'b0}} : cur_row_s + 1'b1) : cur_row_s;
      end
    end
  end

  // Result count (saturating) and output raster position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt_r <= {NW{1'b0}};
      ocol_r    <= {CW{1'b0}};
      orow_r    <= {RW{1'b0}};
    end else if (res_valid) begin
      res_cnt_r <= (res_base_s == RES_TOTAL) ? res_base_s : res_base_s + 1'b1;
      ocol_r    <= o_eol_s ? {CW{1'b0}} : cur_ocol_s + 1'b1;
      orow_r    <= o_eol_s ? (o_eof_s ? {RW{1'b0}} : cur_orow_s + 1'b1) : cur_orow_s;
    end else begin
      res_cnt_r <= res_base_s;
      ocol_r    <= cur_ocol_s;
      orow_r    <= cur_orow_s;
    end
  end

  // Result FIFO storage and transmit scheduling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data_s;
        wr_ptr_r                <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        tx_data_r <= mem_r[rd_ptr_r[AW-1:0]];
        rd_ptr_r  <= rd_ptr_r + 1'b1;
      end
      tx_start_r <= pop_s;
    end
  end

  // Sticky error; a new error in the start cycle wins over the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (drop_s || rx_err_s) begin
      err_r <= 1'b1;
    end else if (start_s) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign pix_valid  = pix_valid_r;
  assign pix_data   = pix_data_r;
  assign pix_col    = pix_col_r;
  assign pix_row    = pix_row_r;
  assign pix_sof    = pix_sof_r;
  assign pix_eol    = pix_eol_r;
  assign pix_eof    = pix_eof_r;
  assign tx_start   = tx_start_r;
  assign tx_data    = tx_data_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign err        = err_r;

endmodule

// File: doc/edge_frame_sequencer.md
# edge_frame_sequencer

Frame-level controller between the UART receiver/transmitter and the Canny edge pipeline inside the chip top level. Turns the raw UART byte stream into a raster-scanned pixel stream with column/row and frame markers. Buffers the pipeline's edge results in a small FIFO and schedules them onto the UART transmitter. Tracks frame completion and protocol errors.

## Interface
- IMG_W, 512: pixels per row.
- IMG_H, 512: rows per frame.
- FIFO_DEPTH, 8: result FIFO entries; must be a power of two and at least 2.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: UART receiver has a byte.
- rx_data  in  8  received byte, valid with rx_valid.
- pix_valid  out  1  one-cycle strobe to the edge pipeline.
- pix_data  out  8  pixel value.
- pix_col  out  $clog2(IMG_W)  column of the pixel.
- pix_row  out  $clog2(IMG_H)  row of the pixel.
- pix_sof  out  1  first pixel of the frame.
- pix_eol  out  1  last pixel of a row.
- pix_eof  out  1  last pixel of the frame.
- res_valid  in  1  one-cycle strobe: the pipeline has a result.
- res_data  in  8  edge result byte.
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  one-cycle request to transmit tx_data.
- tx_data  out  8  byte to transmit.
- busy  out  1  high in STREAM and DRAIN.
- frame_done  out  1  one-cycle pulse at frame end.
- err  out  1  sticky error flag.

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE. Reset state is IDLE.
- IDLE:
  - On rx_valid, clear err and the counters, forward the byte as pixel (0,0) with pix_sof=1, and go to STREAM.
- STREAM:
  - Each rx_valid forwards one pixel. col increments; at IMG_W-1 it wraps to 0 and row increments.
  - pix_eol=1 when col=IMG_W-1.
  - The pixel at (IMG_W-1, IMG_H-1) carries pix_eol=1 and pix_eof=1, and the FSM goes to DRAIN.
- DRAIN:
  - Waits until res_cnt = IMG_W*IMG_H, the FIFO is empty and tx_busy=0, then goes to DONE.
  - rx_valid received in DRAIN is ignored and sets err.
- DONE: frame_done=1 for exactly one cycle, then IDLE.
- Result path, all states:
  - res_valid pushes res_data into the FIFO and increments res_cnt, which is $clog2(IMG_W*IMG_H+1) bits wide and saturates.
  - Output coordinates (ocol, orow) advance per result in the same way as the input counters.
  - Push while full with no pop in the same cycle: the byte is dropped and err is set.
  - Push while full with a pop in the same cycle: the push is accepted.
  - Push while empty: the byte is not forwarded directly to tx in the same cycle.
- TX scheduling:
  - tx_start pulses when the FIFO is non-empty, tx_busy=0 and tx_start was 0 in the previous cycle. This pulse pops the FIFO.
  - tx_data loads the popped byte in the same cycle and holds until the next pop.
- err clears only on rst or on entry from IDLE to STREAM.
- rst mid-frame: FSM returns to IDLE, all counters and FIFO pointers clear, and every output returns to its reset value.

## Timing
- Reset values: pix_valid, pix_sof, pix_eol, pix_eof, tx_start, busy, frame_done and err are 0. pix_data, pix_col, pix_row and tx_data are 0.
- rx_valid in cycle N gives pix_valid and all pix_* fields in cycle N+1; these outputs are registered.
- res_valid in cycle N into an empty FIFO gives tx_start no earlier than N+1, if tx_busy=0.
- Minimum spacing between tx_start pulses is 2 cycles; the transmitter raises tx_busy one cycle after tx_start.
- frame_done is asserted 1 cycle after the DRAIN exit condition is met.
- pix_* outputs other than pix_valid hold their last values between strobes.

## Configuration
- Macro SEQ_BORDER_ZERO_EN.
- Defined: a result whose output coordinate has ocol=0, ocol=IMG_W-1, orow=0 or orow=IMG_H-1 is replaced with 8'h00 before the FIFO push.
- Not defined: res_data is pushed unmodified. The counters still run.

## Test plan
All scenarios use IMG_W=4 and IMG_H=3.
- Reset, then 12 rx_valid with bytes 1..12, and res_valid echoing the same bytes, while tx_busy is held low:
  - pix_sof is 1 on byte 1 only.
  - pix_eol is 1 on bytes 4, 8 and 12.
  - pix_eof is 1 on byte 12 only.
  - tx_start fires 12 times carrying 1..12.
  - frame_done pulses once, then the FSM is IDLE.
- The same run with SEQ_BORDER_ZERO_EN defined: the tx bytes are 0,0,0,0, 0,6,7,0, 0,0,0,0.
- tx_busy held high, then 9 res_valid with 0xA0..0xA8: the ninth byte is dropped and err=1. After tx_busy goes low, 8 tx_start pulses carry 0xA0..0xA7.
- FIFO full, with res_valid and a pop in the same cycle: no drop, err stays 0, and byte order is preserved.
- rx_valid during DRAIN sets err=1. err is then cleared by the first rx_valid of the next frame.
- rst asserted after pixel 5:
  - All outputs are 0 and the FSM is IDLE.
  - The next rx_valid is emitted as col=0, row=0 with pix_sof=1.
